mmio_button_fifo: RTL

//  Memory-mapped input peripheral on the processor's data-memory bus, next to the data RAM.

---
 rtl/mmio_button_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mmio_button_fifo.sv
// Memory-mapped push-button peripheral: synchroniser, debounce, event FIFO and bus registers.
// Optional macro BTN_IRQ_EN adds a registered event-pending interrupt; otherwise irq is tied low.
module mmio_button_fifo #(
  parameter int          NUM_BTN      = 5,
  parameter int          DEBOUNCE_CYC = 250000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [31:0]        addr,
  input  logic               wren,
  input  logic               rden,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               sel,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] sync_q;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic [DB_W-1:0] cnt_reg;

      assign sync_q[gi]  = sync2_reg;
      assign level_q[gi] = level_reg;
      assign accept[gi]  = (sync2_reg != level_reg) && (cnt_reg == DB_MAX);

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_MAX) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end
    end
  endgenerate

  assign btn_level = level_q;

  logic data_hit;
  logic status_hit;
  assign data_hit   = (addr == BASE_ADDR);
  assign status_hit = (addr == BASE_ADDR + 32'd1);
  assign sel        = data_hit | status_hit;

  logic [NUM_BTN-1:0] pending_reg;
  logic [NUM_BTN-1:0] rel_reg;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overflow_reg;
  logic [31:0]        rdata_reg;

  // Lowest pending index wins the single push slot this cycle.
  logic               push_req;
  logic               push_rel;
  logic [2:0]         grant_idx;
  logic [NUM_BTN-1:0] grant_onehot;
  always_comb begin
    push_req     = 1'b0;
    push_rel     = 1'b0;
    grant_idx    = 3'd0;
    grant_onehot = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        push_req        = 1'b1;
        push_rel        = rel_reg[i];
        grant_idx       = 3'(i);
        grant_onehot    = '0;
        grant_onehot[i] = 1'b1;
      end
    end
  end

  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic        overflow_set;
  logic        overflow_clr;
  logic [31:0] push_word;
  logic [31:0] status_word;
  logic [4:0]  count_ext;
  logic [7:0]  level_ext;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == CNT_FULL);
  assign do_pop       = rden & data_hit & ~fifo_empty;
  // A pop in the same cycle frees the slot, so full+pop+push is not an overflow.
  assign do_push      = push_req & (~fifo_full | do_pop);
  assign overflow_set = push_req & fifo_full & ~do_pop;
  assign overflow_clr = wren & status_hit & wdata[15];
  assign push_word    = {24'b0, 1'b1, push_rel, 3'b0, grant_idx};
  assign count_ext    = 5'(count_reg);
  assign level_ext    = 8'(level_q);
  assign status_word  = {16'b0, overflow_reg, 2'b0, count_ext, level_ext};

  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:16], wdata[14:0]};

  always_ff @(posedge clock) begin
    if (do_push) mem[tail_reg] <= push_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_reg  <= '0;
      rel_reg      <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      pending_reg <= (pending_reg & ~grant_onehot) | accept;
      rel_reg     <= (rel_reg & ~accept) | (accept & ~sync_q);
      if (do_push) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // A drop in the clearing cycle still leaves overflow flagged.
      if (overflow_set)      overflow_reg <= 1'b1;
      else if (overflow_clr) overflow_reg <= 1'b0;
      if (rden && data_hit)        rdata_reg <= fifo_empty ? 32'h0 : mem[head_reg];
      else if (rden && status_hit) rdata_reg <= status_word;
      else                         rdata_reg <= 32'h0;
    end
  end

  assign rdata = rdata_reg;

`ifdef BTN_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq_reg <= 1'b0;
    else        irq_reg <= (count_reg != '0) | overflow_reg;
  end
  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

endmodule
